// File: rtl/direction_cmd_encoder.sv
// Debounced, prioritised DE2 key to 2-bit direction command with valid/ready handoff.
// Define CMD_TIMEOUT_EN to abandon an unaccepted command after TIMEOUT_CYCLES.
module direction_cmd_encoder #(
    parameter int DEBOUNCE_CYCLES = 50000,
    parameter int MIN_HOLD_CYCLES = 250000,
    parameter int TIMEOUT_CYCLES  = 1000000
) (
    input  logic       timer,
    input  logic       rst_n,
    input  logic [3:0] key_n,
    input  logic       cmd_ready,
    output logic [1:0] direc,
    output logic       cmd_valid,
    output logic       active,
    output logic       timeout_err
);

    localparam int DEB_N = (DEBOUNCE_CYCLES < 1) ? 1 : DEBOUNCE_CYCLES;
    localparam int DW    = $clog2(DEB_N + 1);
    localparam logic [DW-1:0] DEB_LAST = DW'(DEB_N - 1);
    localparam logic [DW-1:0] DEB_MAX  = DW'(DEB_N);

    localparam int HOLD_N = (MIN_HOLD_CYCLES < 1) ? 1 : MIN_HOLD_CYCLES;
    localparam int HW     = $clog2(HOLD_N + 1);
    localparam logic [HW-1:0] HOLD_LAST = HW'(HOLD_N - 1);

    typedef enum logic [1:0] {IDLE, ISSUE, HOLD, RUN} state_t;

    logic [3:0]    sync1, sync2, keys;
    logic [2:0]    cand, cand_q, deb;
    logic [DW-1:0] deb_cnt;
    logic [HW-1:0] hold_cnt, hold_d;
    logic [1:0]    direc_d;
    logic          err_d;
    state_t        state, state_d;

    always_ff @(posedge timer or negedge rst_n) begin
        if (!rst_n) begin
            sync1 <= 4'hF;
            sync2 <= 4'hF;
        end else begin
            sync1 <= key_n;
            sync2 <= sync1;
        end
    end

    assign keys = ~sync2;

    // {valid, code}; forward+reverse together is a conflict and yields none
    always_comb begin
        cand = 3'b000;
        unique case (1'b1)
            keys[0] && keys[1]:                         cand = 3'b000;
            keys[0] && !keys[1]:                        cand = 3'b100;
            keys[1] && !keys[0]:                        cand = 3'b101;
            !keys[0] && !keys[1] && keys[2]:            cand = 3'b110;
            !keys[0] && !keys[1] && !keys[2] && keys[3]: cand = 3'b111;
            default:                                    cand = 3'b000;
        endcase
    end

    // deb_cnt counts cycles the candidate has been seen unchanged
    always_ff @(posedge timer or negedge rst_n) begin
        if (!rst_n) begin
            cand_q  <= 3'b000;
            deb_cnt <= '0;
            deb     <= 3'b000;
        end else begin
            if (cand != cand_q) begin
                cand_q  <= cand;
                deb_cnt <= DW'(1);
            end else if (deb_cnt != DEB_MAX) begin
                deb_cnt <= deb_cnt + DW'(1);
            end
            if (cand == cand_q && deb_cnt >= DEB_LAST)
                deb <= cand;
        end
    end

`ifdef CMD_TIMEOUT_EN
    localparam int TO_N = (TIMEOUT_CYCLES < 1) ? 1 : TIMEOUT_CYCLES;
    localparam int TW   = $clog2(TO_N + 1);
    localparam logic [TW-1:0] TO_LAST = TW'(TO_N - 1);

    logic [TW-1:0] to_cnt;

    always_ff @(posedge timer or negedge rst_n) begin
        if (!rst_n)
            to_cnt <= '0;
        else if (state == ISSUE)
            to_cnt <= to_cnt + TW'(1);
        else
            to_cnt <= '0;
    end
`endif

    always_comb begin
        state_d = state;
        direc_d = direc;
        hold_d  = hold_cnt;
        err_d   = 1'b0;
        unique case (state)
            IDLE: begin
                if (deb[2]) begin
                    direc_d = deb[1:0];
                    state_d = ISSUE;
                end
            end
            ISSUE: begin
                if (cmd_ready) begin
                    hold_d  = '0;
                    state_d = (MIN_HOLD_CYCLES == 0) ? RUN : HOLD;
                end
`ifdef CMD_TIMEOUT_EN
                else if (to_cnt == TO_LAST) begin
                    err_d   = 1'b1;
                    state_d = IDLE;
                end
`endif
            end
            HOLD: begin
                if (hold_cnt == HOLD_LAST)
                    state_d = RUN;
                else
                    hold_d = hold_cnt + HW'(1);
            end
            RUN: begin
                if (!deb[2]) begin
                    state_d = IDLE;
                end else if (deb[1:0] != direc) begin
                    direc_d = deb[1:0];
                    state_d = ISSUE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge timer or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            direc       <= 2'b00;
            hold_cnt    <= '0;
            timeout_err <= 1'b0;
        end else begin
            state       <= state_d;
            direc       <= direc_d;
            hold_cnt    <= hold_d;
            timeout_err <= err_d;
        end
    end

    assign cmd_valid = (state == ISSUE);
    assign active    = (state == HOLD) || (state == RUN);

endmodule

// File: tb/tb_direction_cmd_encoder.sv
// Directed bench for direction_cmd_encoder with short debounce/hold/timeout.
module tb_direction_cmd_encoder;

    logic       timer = 1'b0;
    logic       rst_n = 1'b0;
    logic [3:0] key_n = 4'hF;
    logic       cmd_ready = 1'b0;
    logic [1:0] direc;
    logic       cmd_valid;
    logic       active;
    logic       timeout_err;

    int tests = 0;
    int fails = 0;

    direction_cmd_encoder #(
        .DEBOUNCE_CYCLES(4),
        .MIN_HOLD_CYCLES(8),
        .TIMEOUT_CYCLES(16)
    ) dut (
        .timer(timer),
        .rst_n(rst_n),
        .key_n(key_n),
        .cmd_ready(cmd_ready),
        .direc(direc),
        .cmd_valid(cmd_valid),
        .active(active),
        .timeout_err(timeout_err)
    );

    always #5 timer = ~timer;

    task automatic tick();
        @(posedge timer);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        key_n = 4'hF;
        cmd_ready = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
    endtask

    // edges counted from the first edge that samples the current key_n
    task automatic wait_valid(output int edges);
        edges = 0;
        while (!cmd_valid && edges < 40) begin
            tick();
            edges++;
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        key_n = 4'hF;
        tick();
        tick();
        tests++;
        if (direc !== 2'b00) begin
            fails++;
            $display("FAIL reset_direc: got %b want 00", direc);
        end
        tests++;
        if (cmd_valid !== 1'b0) begin
            fails++;
            $display("FAIL reset_valid: got %b want 0", cmd_valid);
        end
        tests++;
        if (active !== 1'b0) begin
            fails++;
            $display("FAIL reset_active: got %b want 0", active);
        end
        tests++;
        if (timeout_err !== 1'b0) begin
            fails++;
            $display("FAIL reset_err: got %b want 0", timeout_err);
        end
        rst_n = 1'b1;
        repeat (3) tick();
        tests++;
        if (cmd_valid !== 1'b0 || active !== 1'b0) begin
            fails++;
            $display("FAIL reset_idle: valid %b active %b want 0 0", cmd_valid, active);
        end
    endtask

    task automatic test_left_press();
        int e;
        do_reset();
        key_n = 4'b1011;
        cmd_ready = 1'b1;
        wait_valid(e);
        tests++;
        if (e != 7) begin
            fails++;
            $display("FAIL left_latency: got %0d edges want 7", e);
        end
        tests++;
        if (direc !== 2'b10) begin
            fails++;
            $display("FAIL left_direc: got %b want 10", direc);
        end
        tick();
        tests++;
        if (active !== 1'b1 || cmd_valid !== 1'b0) begin
            fails++;
            $display("FAIL left_accept: active %b valid %b want 1 0", active, cmd_valid);
        end
    endtask

    task automatic test_bounce();
        int e;
        int bad;
        do_reset();
        cmd_ready = 1'b1;
        bad = 0;
        for (int i = 0; i < 10; i++) begin
            key_n = (i % 2 == 0) ? 4'b1110 : 4'b1111;
            repeat (2) begin
                tick();
                if (cmd_valid !== 1'b0) bad++;
            end
        end
        tests++;
        if (bad != 0) begin
            fails++;
            $display("FAIL bounce_quiet: got %0d valid cycles want 0", bad);
        end
        key_n = 4'b1110;
        wait_valid(e);
        tests++;
        if (e != 7) begin
            fails++;
            $display("FAIL bounce_latency: got %0d edges want 7", e);
        end
        tests++;
        if (direc !== 2'b00) begin
            fails++;
            $display("FAIL bounce_direc: got %b want 00", direc);
        end
    endtask

    task automatic test_conflict_priority();
        int e;
        int bad;
        do_reset();
        cmd_ready = 1'b1;
        key_n = 4'b1100;
        bad = 0;
        repeat (20) begin
            tick();
            if (cmd_valid !== 1'b0 || active !== 1'b0) bad++;
        end
        tests++;
        if (bad != 0) begin
            fails++;
            $display("FAIL conflict_quiet: got %0d busy cycles want 0", bad);
        end
        key_n = 4'b0101;
        wait_valid(e);
        tests++;
        if (e != 7) begin
            fails++;
            $display("FAIL prio_latency: got %0d edges want 7", e);
        end
        tests++;
        if (direc !== 2'b01) begin
            fails++;
            $display("FAIL prio_direc: got %b want 01", direc);
        end
    endtask

    task automatic test_hold_change();
        int e;
        int bad;
        do_reset();
        cmd_ready = 1'b1;
        key_n = 4'b0111;
        wait_valid(e);
        tests++;
        if (direc !== 2'b11) begin
            fails++;
            $display("FAIL hold_first_direc: got %b want 11", direc);
        end
        tick();
        tests++;
        if (active !== 1'b1) begin
            fails++;
            $display("FAIL hold_active: got %b want 1", active);
        end
        tick();
        tick();
        key_n = 4'b1110;
        cmd_ready = 1'b0;
        bad = 0;
        e = 0;
        while (!cmd_valid && e < 40) begin
            tick();
            e++;
            if (!cmd_valid && (direc !== 2'b11 || active !== 1'b1)) bad++;
        end
        tests++;
        if (bad != 0) begin
            fails++;
            $display("FAIL hold_frozen: got %0d bad cycles want 0", bad);
        end
        tests++;
        if (e != 7) begin
            fails++;
            $display("FAIL hold_change_latency: got %0d edges want 7", e);
        end
        tests++;
        if (direc !== 2'b00) begin
            fails++;
            $display("FAIL hold_new_direc: got %b want 00", direc);
        end
        bad = 0;
        repeat (5) begin
            tick();
            if (cmd_valid !== 1'b1 || direc !== 2'b00 || active !== 1'b0) bad++;
        end
        tests++;
        if (bad != 0) begin
            fails++;
            $display("FAIL stall_stable: got %0d bad cycles want 0", bad);
        end
        cmd_ready = 1'b1;
        tick();
        tests++;
        if (cmd_valid !== 1'b0 || active !== 1'b1 || direc !== 2'b00) begin
            fails++;
            $display("FAIL stall_accept: valid %b active %b direc %b want 0 1 00",
                     cmd_valid, active, direc);
        end
    endtask

    task automatic test_async_reset();
        int e;
        do_reset();
        cmd_ready = 1'b1;
        key_n = 4'b0111;
        wait_valid(e);
        tick();
        tests++;
        if (active !== 1'b1 || direc !== 2'b11) begin
            fails++;
            $display("FAIL async_pre: active %b direc %b want 1 11", active, direc);
        end
        #2;
        rst_n = 1'b0;
        #1;
        tests++;
        if (direc !== 2'b00 || cmd_valid !== 1'b0 || active !== 1'b0 || timeout_err !== 1'b0) begin
            fails++;
            $display("FAIL async_reset: direc %b valid %b active %b err %b want 00 0 0 0",
                     direc, cmd_valid, active, timeout_err);
        end
        key_n = 4'hF;
        rst_n = 1'b1;
    endtask

`ifdef CMD_TIMEOUT_EN
    task automatic test_timeout();
        int e;
        int n;
        do_reset();
        cmd_ready = 1'b0;
        key_n = 4'b1110;
        wait_valid(e);
        n = 0;
        while (cmd_valid && n < 40) begin
            tick();
            n++;
        end
        tests++;
        if (n != 16) begin
            fails++;
            $display("FAIL timeout_len: got %0d cycles want 16", n);
        end
        tests++;
        if (timeout_err !== 1'b1 || active !== 1'b0) begin
            fails++;
            $display("FAIL timeout_pulse: err %b active %b want 1 0", timeout_err, active);
        end
        tick();
        tests++;
        if (cmd_valid !== 1'b1 || timeout_err !== 1'b0 || direc !== 2'b00) begin
            fails++;
            $display("FAIL timeout_reissue: valid %b err %b direc %b want 1 0 00",
                     cmd_valid, timeout_err, direc);
        end
    endtask
`else
    task automatic test_no_timeout();
        int e;
        int bad;
        do_reset();
        cmd_ready = 1'b0;
        key_n = 4'b1110;
        wait_valid(e);
        bad = 0;
        repeat (30) begin
            tick();
            if (cmd_valid !== 1'b1 || timeout_err !== 1'b0 || active !== 1'b0) bad++;
        end
        tests++;
        if (bad != 0) begin
            fails++;
            $display("FAIL no_timeout_wait: got %0d bad cycles want 0", bad);
        end
    endtask
`endif

    initial begin
        test_reset();
        test_left_press();
        test_bounce();
        test_conflict_priority();
        test_hold_change();
        test_async_reset();
`ifdef CMD_TIMEOUT_EN
        test_timeout();
`else
        test_no_timeout();
`endif
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
